// File: rtl/decode_stage_pipe_pkg.sv
// rtl/decode_stage_pipe_pkg.sv - opcode/funct constants, ALU control codes and instruction classifier
package decode_stage_pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_SLT   = 6'd42;

   typedef enum logic [2:0] {
      ALU_NONE = 3'b000,
      ALU_ADD  = 3'b010,
      ALU_SUB  = 3'b110
   } alu_ctr_e;

   typedef enum logic [2:0] {
      CLS_ILLEGAL, CLS_ADD, CLS_SUB, CLS_SLT, CLS_LW, CLS_SW, CLS_BEQ, CLS_J
   } op_cls_e;

   function automatic op_cls_e classify(input logic [5:0] op, input logic [5:0] fn);
      op_cls_e c;
      c = CLS_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD:  c = CLS_ADD;
               FN_SUB:  c = CLS_SUB;
               FN_SLT:  c = CLS_SLT;
               default: c = CLS_ILLEGAL;
            endcase
         end
         OP_LW:   c = CLS_LW;
         OP_SW:   c = CLS_SW;
         OP_BEQ:  c = CLS_BEQ;
         OP_J:    c = CLS_J;
         default: c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - IF-side and EX-side handshake/payload bundle of the ID stage
interface decode_stage_pipe_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ir;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [XLEN-1:0] out_store_data;
   logic [XLEN-1:0] out_imm;
   logic [AW-1:0]   out_rd;
   logic            out_rd_we;
   logic [2:0]      out_alu_ctr;
   logic            out_is_slt;
   logic            out_is_load;
   logic            out_is_store;
   logic            out_is_branch;
   logic            out_is_jump;
   logic [XLEN-1:0] out_br_target;
   logic [XLEN-1:0] out_j_target;
   logic            out_illegal;

   modport master (
      output in_valid, in_ir, in_pc, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_store_data, out_imm, out_rd, out_rd_we,
             out_alu_ctr, out_is_slt, out_is_load, out_is_store, out_is_branch, out_is_jump,
             out_br_target, out_j_target, out_illegal
   );

   modport slave (
      input  in_valid, in_ir, in_pc, out_ready,
      output in_ready, out_valid, out_a, out_b, out_store_data, out_imm, out_rd, out_rd_we,
             out_alu_ctr, out_is_slt, out_is_load, out_is_store, out_is_branch, out_is_jump,
             out_br_target, out_j_target, out_illegal
   );
endinterface

// File: rtl/decode_stage_pipe_reg_file_2r1w.sv
// rtl/decode_stage_pipe_reg_file_2r1w.sv - 2-read 1-write register file with write-through bypass
module reg_file_2r1w #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr_a,
   output logic [XLEN-1:0] rdata_a,
   input  logic [AW-1:0]   raddr_b,
   output logic [XLEN-1:0] rdata_b
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   always_comb begin
      regs_d = regs_q;
      if (we && waddr != '0) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // A register being written this cycle is read as its new value.
   assign rdata_a = (raddr_a == '0) ? '0 : (we && waddr == raddr_a) ? wdata : regs_q[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : (we && waddr == raddr_b) ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - ID stage: decode, load-use bubble, output pipeline register, stall counter
module decode_stage_pipe
   import decode_stage_pipe_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NREG        = 32,
   parameter int STALL_CNT_W = 16,
   localparam int AW         = $clog2(NREG)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   decode_stage_pipe_if.slave     bus,
   input  logic                   wb_we,
   input  logic [AW-1:0]          wb_rd,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] sd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] brt;
      logic [XLEN-1:0] jt;
      logic [AW-1:0]   rd;
      logic            rd_we;
      alu_ctr_e        ctr;
      logic            slt;
      logic            load;
      logic            store;
      logic            branch;
      logic            jump;
      logic            illegal;
   } payload_t;

   logic [AW-1:0]          rs_a, rt_a;
   logic [XLEN-1:0]        rs_val, rt_val, imm, pc4;
   op_cls_e                cls;
   payload_t               dec, pay_d, pay_q;
   logic                   reads_rs, reads_rt, hazard, accept;
   logic                   valid_d, valid_q;
   logic [STALL_CNT_W-1:0] stall_d, stall_q;

   reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wb_we),
      .waddr   (wb_rd),
      .wdata   (wb_data),
      .raddr_a (rs_a),
      .rdata_a (rs_val),
      .raddr_b (rt_a),
      .rdata_b (rt_val)
   );

   assign rs_a = bus.in_ir[21 +: AW];
   assign rt_a = bus.in_ir[16 +: AW];
   assign cls  = classify(bus.in_ir[31:26], bus.in_ir[5:0]);
   assign imm  = {{(XLEN-16){bus.in_ir[15]}}, bus.in_ir[15:0]};
   assign pc4  = bus.in_pc + XLEN'(4);

   always_comb begin
      dec        = '0;
      dec.a      = rs_val;
      dec.b      = rt_val;
      dec.sd     = rt_val;
      dec.imm    = imm;
      dec.brt    = pc4 + (imm << 2);
      dec.jt     = {pc4[XLEN-1:28], bus.in_ir[25:0], 2'b00};
      dec.ctr    = ALU_NONE;
      reads_rs   = 1'b1;
      reads_rt   = 1'b0;
      case (cls)
         CLS_ADD, CLS_SUB, CLS_SLT: begin
            dec.rd    = bus.in_ir[11 +: AW];
            dec.rd_we = 1'b1;
            dec.ctr   = (cls == CLS_ADD) ? ALU_ADD : ALU_SUB;
            dec.slt   = (cls == CLS_SLT);
            reads_rt  = 1'b1;
         end
         CLS_LW: begin
            dec.b     = imm;
            dec.rd    = rt_a;
            dec.rd_we = 1'b1;
            dec.ctr   = ALU_ADD;
            dec.load  = 1'b1;
         end
         CLS_SW: begin
            dec.b     = imm;
            dec.ctr   = ALU_ADD;
            dec.store = 1'b1;
            reads_rt  = 1'b1;
         end
         CLS_BEQ: begin
            dec.ctr    = ALU_SUB;
            dec.branch = 1'b1;
            reads_rt   = 1'b1;
         end
         CLS_J: begin
            dec.jump = 1'b1;
            reads_rs = 1'b0;
         end
         default: begin
            dec.illegal = 1'b1;
            reads_rt    = (bus.in_ir[31:26] == OP_RTYPE);
         end
      endcase
   end

   // A load in the output register cannot forward to a consumer decoded right behind it.
   assign hazard = valid_q && pay_q.load && (pay_q.rd != '0) && bus.in_valid &&
                   ((reads_rs && rs_a == pay_q.rd) || (reads_rt && rt_a == pay_q.rd));
   assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      valid_d = valid_q;
      pay_d   = pay_q;
      stall_d = stall_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         pay_d   = dec;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
      if (hazard && stall_q != '1) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pay_q   <= '0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         pay_q   <= pay_d;
         stall_q <= stall_d;
      end
   end

   assign bus.out_valid      = valid_q;
   assign bus.out_a          = pay_q.a;
   assign bus.out_b          = pay_q.b;
   assign bus.out_store_data = pay_q.sd;
   assign bus.out_imm        = pay_q.imm;
   assign bus.out_rd         = pay_q.rd;
   assign bus.out_rd_we      = pay_q.rd_we;
   assign bus.out_alu_ctr    = pay_q.ctr;
   assign bus.out_is_slt     = pay_q.slt;
   assign bus.out_is_load    = pay_q.load;
   assign bus.out_is_store   = pay_q.store;
   assign bus.out_is_branch  = pay_q.branch;
   assign bus.out_is_jump    = pay_q.jump;
   assign bus.out_br_target  = pay_q.brt;
   assign bus.out_j_target   = pay_q.jt;
   assign bus.out_illegal    = pay_q.illegal;
   assign stall_cnt          = stall_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - table-driven and scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;

   localparam logic [5:0] F_SLT = 6'b100000, F_LD = 6'b010000, F_ST = 6'b001000;
   localparam logic [5:0] F_BR  = 6'b000100, F_JP = 6'b000010, F_IL = 6'b000001;

   typedef struct packed {
      logic [31:0] a, b, sd;
      logic [4:0]  rd;
      logic        rd_we;
      logic [2:0]  ctr;
      logic [5:0]  fl;
   } exp_t;

   typedef struct packed {
      logic [31:0] ir, pc;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic [15:0] stall_cnt;

   decode_stage_pipe_if #(.XLEN(32), .AW(5)) bus ();

   decode_stage_pipe #(.XLEN(32), .NREG(32), .STALL_CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .flush     (flush),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   vec_t        q[$];
   vec_t        tbl[10];
   exp_t        cur_exp;
   int          n_chk = 0;
   int          n_fail = 0;
   int          waited;
   logic [15:0] exp_stall;
   logic        last_acc;

   function automatic logic [31:0] rtype(input int rs, rt, rd, input logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction
   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, rt, input logic [15:0] im);
      return {op, 5'(rs), 5'(rt), im};
   endfunction
   function automatic logic [31:0] jtype(input logic [25:0] t);
      return {6'd2, t};
   endfunction
   function automatic exp_t mk(input logic [31:0] a, b, sd, input int rd, input logic we,
                               input logic [2:0] ctr, input logic [5:0] fl);
      exp_t e;
      e.a = a; e.b = b; e.sd = sd; e.rd = 5'(rd); e.rd_we = we; e.ctr = ctr; e.fl = fl;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_head(input vec_t h);
      logic [31:0] im, pc4;
      im  = {{16{h.ir[15]}}, h.ir[15:0]};
      pc4 = h.pc + 32'd4;
      chk("out_a", bus.out_a, h.e.a);
      if (!(h.e.fl[1] || h.e.fl[0])) chk("out_b", bus.out_b, h.e.b);
      chk("out_store_data", bus.out_store_data, h.e.sd);
      chk("out_imm", bus.out_imm, im);
      if (h.e.rd_we) chk("out_rd", 32'(bus.out_rd), 32'(h.e.rd));
      chk("out_rd_we", 32'(bus.out_rd_we), 32'(h.e.rd_we));
      chk("out_alu_ctr", 32'(bus.out_alu_ctr), 32'(h.e.ctr));
      chk("out_flags", 32'({bus.out_is_slt, bus.out_is_load, bus.out_is_store, bus.out_is_branch,
                            bus.out_is_jump, bus.out_illegal}), 32'(h.e.fl));
      chk("out_br_target", bus.out_br_target, pc4 + (im << 2));
      chk("out_j_target", bus.out_j_target, {pc4[31:28], h.ir[25:0], 2'b00});
   endtask

   function automatic logic reads_rt(input logic [31:0] ir);
      return ir[31:26] == 6'd0 || ir[31:26] == 6'd43 || ir[31:26] == 6'd4;
   endfunction

   task automatic tick();
      logic hz, rdy;
      vec_t h, n;
      @(negedge clk);
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      hz = 1'b0;
      if (q.size() != 0) begin
         h = q[0];
         check_head(h);
         hz = h.e.fl[4] && h.e.rd != 5'd0 && bus.in_valid &&
              ((bus.in_ir[31:26] != 6'd2 && bus.in_ir[25:21] == h.e.rd) ||
               (reads_rt(bus.in_ir) && bus.in_ir[20:16] == h.e.rd));
      end
      rdy = (q.size() == 0 || bus.out_ready) && !hz && !flush;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      last_acc = bus.in_valid && rdy;
      if (q.size() != 0 && (bus.out_ready || flush)) void'(q.pop_front());
      if (last_acc) begin
         n.ir = bus.in_ir; n.pc = bus.in_pc; n.e = cur_exp;
         q.push_back(n);
      end
      if (hz && exp_stall != 16'hFFFF) exp_stall++;
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] ir, pc, input exp_t e);
      bus.in_valid = 1'b1; bus.in_ir = ir; bus.in_pc = pc; cur_exp = e;
   endtask

   task automatic issue(input logic [31:0] ir, pc, input exp_t e);
      present(ir, pc, e);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!last_acc && waited < 20);
      if (!last_acc) chk("issue_timeout", 32'(last_acc), 32'd1);
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      chk("drain_valid", 32'(bus.out_valid), 32'd0);
   endtask

   task automatic wb(input int rd, input logic [31:0] d);
      wb_we = 1'b1; wb_rd = 5'(rd); wb_data = d;
      tick();
      wb_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      bus.in_valid = 1'b0; bus.in_ir = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
      exp_stall = '0; cur_exp = '0; last_acc = 1'b0;

      // r1=0x100, r2=5, r3=0xFFFFFFF0 preloaded below; others are 0
      tbl[0] = '{rtype(1, 2, 4, 6'd32), 32'h0,  mk(32'h100, 32'h5, 32'h5, 4, 1, 3'b010, 6'd0)};
      tbl[1] = '{rtype(2, 1, 5, 6'd34), 32'h4,  mk(32'h5, 32'h100, 32'h100, 5, 1, 3'b110, 6'd0)};
      tbl[2] = '{rtype(3, 2, 6, 6'd42), 32'h8,  mk(32'hFFFFFFF0, 32'h5, 32'h5, 6, 1, 3'b110, F_SLT)};
      tbl[3] = '{itype(6'd35, 1, 7, 16'hFFF8), 32'hC, mk(32'h100, 32'hFFFFFFF8, 32'h0, 7, 1, 3'b010, F_LD)};
      tbl[4] = '{itype(6'd43, 3, 2, 16'd12), 32'h10, mk(32'hFFFFFFF0, 32'hC, 32'h5, 0, 0, 3'b010, F_ST)};
      tbl[5] = '{itype(6'd4, 1, 2, 16'hFFFF), 32'h14, mk(32'h100, 32'h5, 32'h5, 0, 0, 3'b110, F_BR)};
      tbl[6] = '{jtype(26'h40), 32'h18, mk(32'h0, 32'h0, 32'h0, 0, 0, 3'b000, F_JP)};
      tbl[7] = '{itype(6'd63, 1, 2, 16'h0), 32'h1C, mk(32'h100, 32'h0, 32'h5, 0, 0, 3'b000, F_IL)};
      tbl[8] = '{rtype(1, 2, 9, 6'h21), 32'h20, mk(32'h100, 32'h0, 32'h5, 0, 0, 3'b000, F_IL)};
      tbl[9] = '{rtype(0, 3, 8, 6'd32), 32'h24, mk(32'h0, 32'hFFFFFFF0, 32'hFFFFFFF0, 8, 1, 3'b010, 6'd0)};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_out_a", bus.out_a, 32'd0);
      chk("rst_br_target", bus.out_br_target, 32'd0);
      rst_n = 1'b1;

      wb(1, 32'h100);
      wb(2, 32'h5);
      wb(3, 32'hFFFFFFF0);

      for (int i = 0; i < 10; i++) issue(tbl[i].ir, tbl[i].pc, tbl[i].e);
      drain();

      // write-through bypass: r5 written in the same cycle it is read
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
      issue(rtype(5, 0, 3, 6'd32), 32'h40, mk(32'h1234, 32'h0, 32'h0, 3, 1, 3'b010, 6'd0));
      wb_we = 1'b0;
      drain();

      // load-use: lw r4,8(r1) ; add r2,r4,r4
      issue(itype(6'd35, 1, 4, 16'd8), 32'h50, mk(32'h100, 32'h8, 32'h0, 4, 1, 3'b010, F_LD));
      issue(rtype(4, 4, 2, 6'd32), 32'h54, mk(32'h0, 32'h0, 32'h0, 2, 1, 3'b010, 6'd0));
      chk("lu_wait_cycles", 32'(waited), 32'd2);
      drain();
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // backpressure for three cycles with a second instruction waiting
      bus.out_ready = 1'b0;
      issue(rtype(1, 2, 4, 6'd32), 32'h60, mk(32'h100, 32'h5, 32'h5, 4, 1, 3'b010, 6'd0));
      present(rtype(2, 1, 5, 6'd34), 32'h64, mk(32'h5, 32'h100, 32'h100, 5, 1, 3'b110, 6'd0));
      repeat (3) tick();
      bus.out_ready = 1'b1;
      issue(rtype(2, 1, 5, 6'd34), 32'h64, mk(32'h5, 32'h100, 32'h100, 5, 1, 3'b110, 6'd0));
      chk("bp_resume_wait", 32'(waited), 32'd1);
      drain();

      // branch/jump targets
      issue(itype(6'd4, 1, 2, 16'hFFFF), 32'h100, mk(32'h100, 32'h5, 32'h5, 0, 0, 3'b110, F_BR));
      chk("beq_imm", bus.out_imm, 32'hFFFFFFFF);
      chk("beq_target", bus.out_br_target, 32'h100);
      issue(jtype(26'h40), 32'h200, mk(32'h0, 32'h0, 32'h0, 0, 0, 3'b000, F_JP));
      chk("j_target", bus.out_j_target, 32'h100);
      drain();

      // flush while output stalled and a new instruction is offered
      bus.out_ready = 1'b0;
      issue(rtype(1, 2, 4, 6'd32), 32'h70, mk(32'h100, 32'h5, 32'h5, 4, 1, 3'b010, 6'd0));
      present(rtype(2, 1, 5, 6'd34), 32'h74, mk(32'h5, 32'h100, 32'h100, 5, 1, 3'b110, 6'd0));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      // asynchronous reset with a held payload and a nonzero stall count
      bus.out_ready = 1'b0;
      issue(rtype(1, 2, 4, 6'd32), 32'h80, mk(32'h100, 32'h5, 32'h5, 4, 1, 3'b010, 6'd0));
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("arst_out_a", bus.out_a, 32'd0);
      chk("arst_out_rd_we", 32'(bus.out_rd_we), 32'd0);
      chk("arst_alu_ctr", 32'(bus.out_alu_ctr), 32'd0);
      q.delete();
      exp_stall = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      issue(rtype(5, 1, 3, 6'd32), 32'h90, mk(32'h0, 32'h0, 32'h0, 3, 1, 3'b010, 6'd0));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
